fft_stage_engine: RTL and testbench
===================================

FFT_STAGE_ENGINE -- requirements
Module: fft_stage_engine

Interface
REQ-001 Parameter N_PTS, default 32: transform length; power of 2, at least 4.
REQ-002 Parameter N_BFLY, default 4: parallel butterfly units; power of 2, from 1 to N_PTS/2.
REQ-003 Parameter DW, default 16: signed two's-complement width of each real/imag component at the input.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input sample valid.
REQ-007 in_ready  out  1  block accepts an input sample.
REQ-008 in_data  in  2*DW  complex sample; real part in the upper DW bits, imag part in the lower DW bits.
REQ-009 out_valid  out  1  output sample valid.
REQ-010 out_ready  in  1  downstream accepts an output sample.
REQ-011 out_data  out  2*(DW+1)  complex result; real part upper, imag part lower, each DW+1 bits.
REQ-012 out_last  out  1  high with the final output sample of a frame.
REQ-013 busy  out  1  high in COMPUTE and UNLOAD.
REQ-014 done  out  1  one-cycle pulse when a frame's last output is accepted.

Function
REQ-015 FSM states: LOAD, COMPUTE, FLUSH, UNLOAD.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready beat writes in_buf[wr_idx], samples in natural order, wr_idx incrementing from 0.
REQ-017 LOAD->COMPUTE on the beat that writes index N_PTS-1; wr_idx then wraps to 0.
REQ-018 COMPUTE lasts exactly N_PTS/(2*N_BFLY) cycles, counted by cyc from 0.
REQ-019 In COMPUTE cycle c, unit u handles butterfly m=c*N_BFLY+u.
REQ-020 Operands for butterfly m: a=in_buf[bitrev(2m)], b=in_buf[bitrev(2m)+N_PTS/2]; bitrev is over log2(N_PTS) bits.
REQ-021 Results: y[2m]=a+b and y[2m+1]=a-b, computed per component.
REQ-022 Operands sign-extend to DW+1 bits before add/sub; no saturation or overflow is possible.
REQ-023 Butterfly results are registered (latency 1) and written to out_buf on the following cycle.
REQ-024 FLUSH is exactly 1 cycle; it writes the final butterfly results, then the FSM enters UNLOAD.
REQ-025 UNLOAD: out_valid=1 and out_data=out_buf[rd_idx], natural order from 0.
REQ-026 rd_idx advances only on out_valid&out_ready; out_data is held stable while out_ready=0.
REQ-027 out_last = out_valid & (rd_idx==N_PTS-1).
REQ-028 On the accepted last beat: done pulses the next cycle, the FSM returns to LOAD, and rd_idx wraps to 0.
REQ-029 in_ready=0 outside LOAD; in_valid outside LOAD is ignored and no buffer is written.
REQ-030 out_valid=0 outside UNLOAD; out_ready outside UNLOAD has no effect.
REQ-031 Frame throughput: N_PTS load cycles + N_PTS/(2*N_BFLY) + 1 compute cycles + N_PTS unload cycles, with no stalls.

Reset
REQ-032 In any state, reset forces state=LOAD and wr_idx=rd_idx=cyc=0.
REQ-033 Reset forces the pipeline valid register to 0, busy=0, done=0 and out_valid=0; in_ready=1 on the first cycle after reset deasserts.
REQ-034 Buffer contents are not reset; a partial frame is discarded and out_buf is never presented before a complete recompute.

Structure
REQ-035 A shared package fft_pkg holds the state enum, the clog2-derived index widths, and the bitrev function.
REQ-036 Sub-module fft_bfly2 (one complex add/sub pair, parameter DW, combinational) is instantiated N_BFLY times via generate.
REQ-037 in_buf and out_buf are flop arrays indexed by the counters; no vendor RAM is used.

Verification
REQ-038 N_PTS=8, N_BFLY=2, DW=16; x[n]=n+0j -> out real = 4,-4,8,-4,6,-4,10,-4, imag all 0; done pulses once.
REQ-039 Same config, x[n]=0+1j for all n -> out = 0+2j,0+0j repeating; out_last only on the 8th beat.
REQ-040 Default config; x[0]=32767, x[16]=32767 (real), others 0 -> y[0]=65534 (17-bit, no wrap), y[1]=0.
REQ-041 Random out_ready backpressure and in_valid gaps -> results match a reference model; frame length and order unchanged.
REQ-042 Assert reset after 5 load beats, then load a full frame x[n]=n -> outputs match REQ-038 with no stale data.
REQ-043 Two back-to-back frames -> in_ready rises the cycle after done; the second frame's results are correct.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT stage engine.
package fft_pkg;

    typedef enum logic [1:0] {LOAD, COMPUTE, FLUSH, UNLOAD} state_t;

    localparam int unsigned MAX_IDX_W = 16;

    // Index width for a counter spanning n values (never narrower than 1 bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reverse the low 'bits' bits of v.
    function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] v,
                                                    input int unsigned bits);
        logic [MAX_IDX_W-1:0] r;
        r = {<<{v}};
        return r >> (MAX_IDX_W - bits);
    endfunction

endpackage

// File: rtl/fft_bfly2.sv
// One complex radix-2 butterfly: y0 = a + b, y1 = a - b, widened by one bit.
module fft_bfly2 #(
    parameter int unsigned DW = 16
) (
    input  logic [2*DW-1:0]     a,
    input  logic [2*DW-1:0]     b,
    output logic [2*(DW+1)-1:0] y0_c,
    output logic [2*(DW+1)-1:0] y1_c
);

    logic signed [DW:0] ar, ai, br, bi;

    assign ar = {a[2*DW-1], a[2*DW-1:DW]};
    assign ai = {a[DW-1],   a[DW-1:0]};
    assign br = {b[2*DW-1], b[2*DW-1:DW]};
    assign bi = {b[DW-1],   b[DW-1:0]};

    assign y0_c = {ar + br, ai + bi};
    assign y1_c = {ar - br, ai - bi};

endmodule

// File: rtl/fft_stage_engine.sv
// Frame-buffered radix-2 stage: load N_PTS samples, run N_BFLY butterflies per
// cycle over bit-reversed operands, then stream results out in natural order.
module fft_stage_engine
    import fft_pkg::*;
#(
    parameter int unsigned N_PTS  = 32,
    parameter int unsigned N_BFLY = 4,
    parameter int unsigned DW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*DW-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*(DW+1)-1:0]  out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IW    = idx_w(N_PTS);
    localparam int unsigned N_CYC = N_PTS / (2 * N_BFLY);
    localparam int unsigned CW    = idx_w(N_CYC);
    localparam int unsigned OW    = 2 * (DW + 1);

    state_t          state, state_n;
    logic [IW-1:0]   wr_idx, wr_n, rd_idx, rd_n;
    logic [CW-1:0]   cyc, cyc_n;
    logic            in_fire, out_fire;
    logic            in_ready_n, out_valid_n, out_last_n, busy_n, done_n;

    logic [2*DW-1:0] in_buf  [N_PTS];
    logic [OW-1:0]   out_buf [N_PTS];

    logic            pipe_valid;
    logic [IW-1:0]   pipe_m;
    logic [OW-1:0]   pipe_y0 [N_BFLY];
    logic [OW-1:0]   pipe_y1 [N_BFLY];
    logic [OW-1:0]   y0_c    [N_BFLY];
    logic [OW-1:0]   y1_c    [N_BFLY];
    logic [IW-1:0]   w_idx0  [N_BFLY];
    logic [IW-1:0]   w_idx1  [N_BFLY];
    logic [OW-1:0]   out_data_n;

    assign in_fire  = in_valid  && (state == LOAD);
    assign out_fire = out_ready && (state == UNLOAD);

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            wr_idx    <= '0;
            rd_idx    <= '0;
            cyc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            wr_idx    <= wr_n;
            rd_idx    <= rd_n;
            cyc       <= cyc_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state, counters and next values of the status outputs.
    always_comb begin
        state_n = state;
        wr_n    = wr_idx;
        rd_n    = rd_idx;
        cyc_n   = cyc;
        case (state)
            LOAD: begin
                if (in_fire) begin
                    if (wr_idx == IW'(N_PTS - 1)) begin
                        wr_n    = '0;
                        cyc_n   = '0;
                        state_n = COMPUTE;
                    end else begin
                        wr_n = wr_idx + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (cyc == CW'(N_CYC - 1)) begin
                    cyc_n   = '0;
                    state_n = FLUSH;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            FLUSH: begin
                rd_n    = '0;
                state_n = UNLOAD;
            end
            UNLOAD: begin
                if (out_fire) begin
                    if (rd_idx == IW'(N_PTS - 1)) begin
                        rd_n    = '0;
                        state_n = LOAD;
                    end else begin
                        rd_n = rd_idx + 1'b1;
                    end
                end
            end
        endcase
        in_ready_n  = (state_n == LOAD);
        out_valid_n = (state_n == UNLOAD);
        out_last_n  = (state_n == UNLOAD) && (rd_n == IW'(N_PTS - 1));
        busy_n      = (state_n != LOAD);
        done_n      = out_fire && (rd_idx == IW'(N_PTS - 1));
    end

    for (genvar u = 0; u < N_BFLY; u++) begin : g_bfly
        logic [IW-1:0] m_idx, a_idx, b_idx;

        assign m_idx = IW'(int'(cyc) * N_BFLY + u);
        assign a_idx = IW'(bitrev(MAX_IDX_W'({m_idx[IW-2:0], 1'b0}), IW));
        assign b_idx = a_idx + IW'(N_PTS / 2);

        fft_bfly2 #(.DW(DW)) u_bfly (
            .a    (in_buf[a_idx]),
            .b    (in_buf[b_idx]),
            .y0_c (y0_c[u]),
            .y1_c (y1_c[u])
        );

        assign w_idx0[u] = IW'((int'(pipe_m) + u) * 2);
        assign w_idx1[u] = w_idx0[u] | IW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= 1'b0;
        end else begin
            pipe_valid <= (state == COMPUTE);
        end
    end

    // Datapath storage; buffer contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        pipe_m <= IW'(int'(cyc) * N_BFLY);
        for (int unsigned u = 0; u < N_BFLY; u++) begin
            pipe_y0[u] <= y0_c[u];
            pipe_y1[u] <= y1_c[u];
        end
        if (in_fire) begin
            in_buf[wr_idx] <= in_data;
        end
        if (pipe_valid) begin
            for (int unsigned u = 0; u < N_BFLY; u++) begin
                out_buf[w_idx0[u]] <= pipe_y0[u];
                out_buf[w_idx1[u]] <= pipe_y1[u];
            end
        end
        out_data <= out_data_n;
    end

    // Forward a same-edge out_buf write so out_data can be registered.
    always_comb begin
        out_data_n = out_buf[rd_n];
        for (int unsigned u = 0; u < N_BFLY; u++) begin
            if (pipe_valid && (w_idx0[u] == rd_n)) out_data_n = pipe_y0[u];
            if (pipe_valid && (w_idx1[u] == rd_n)) out_data_n = pipe_y1[u];
        end
    end

endmodule

// File: tb/tb_fft_stage_engine.sv
// Directed/random scoreboard bench for fft_stage_engine (8-point and 32-point builds).
module tb_fft_stage_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [2];
    logic [31:0] in_data   [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_last  [2];
    logic        busy      [2];
    logic        done      [2];
    logic [33:0] out_data  [2];

    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt [2] = '{0, 0};
    logic [33:0] exp_q [$];
    logic [31:0] stim [32];
    int          r38 [8] = '{4, -4, 8, -4, 6, -4, 10, -4};

    always #5 clk = ~clk;

    fft_stage_engine #(.N_PTS(8), .N_BFLY(2), .DW(16)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
    );

    fft_stage_engine dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
    );

    always @(negedge clk) begin
        if (done[0]) done_cnt[0]++;
        if (done[1]) done_cnt[1]++;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check34(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] pk(input int re, input int im);
        logic [16:0] r, i;
        r = 17'(re);
        i = 17'(im);
        return {r, i};
    endfunction

    function automatic int rev(input int v, input int n);
        int bits = $clog2(n);
        int r = 0;
        for (int i = 0; i < bits; i++) if (v[i]) r |= (1 << (bits - 1 - i));
        return r;
    endfunction

    task automatic push_model(input int n);
        for (int m = 0; m < n / 2; m++) begin
            int ia = rev(2 * m, n);
            int ib = ia + n / 2;
            shortint ar, ai, br, bi;
            ar = stim[ia][31:16]; ai = stim[ia][15:0];
            br = stim[ib][31:16]; bi = stim[ib][15:0];
            exp_q.push_back(pk(int'(ar) + int'(br), int'(ai) + int'(bi)));
            exp_q.push_back(pk(int'(ar) - int'(br), int'(ai) - int'(bi)));
        end
    endtask

    task automatic push_ramp8();
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(r38[i], 0));
    endtask

    task automatic load(input int sel, input int n, input bit gaps);
        bit rdy;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid[sel] = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid[sel] = 1'b1;
            in_data[sel]  = stim[i];
            rdy = 1'b0;
            for (int t = 0; t < 64 && !rdy; t++) begin
                rdy = in_ready[sel];
                @(posedge clk);
                @(negedge clk);
            end
            check1("load_accept", rdy, 1'b1);
        end
        in_valid[sel] = 1'b0;
    endtask

    task automatic unload(input int sel, input int n, input bit bp);
        int          beat = 0;
        bit          rdy, holding = 1'b0, first = 1'b1;
        logic [33:0] held, e;
        int          d0 = done_cnt[sel];
        for (int t = 0; t < 2000 && beat < n; t++) begin
            if (holding && out_valid[sel]) check34("hold_stable", out_data[sel], held);
            holding = 1'b0;
            if (out_valid[sel] && first) begin
                check1("busy_unload", busy[sel], 1'b1);
                check1("in_ready_unload", in_ready[sel], 1'b0);
                first = 1'b0;
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready[sel] = rdy;
            in_valid[sel]  = 1'b1;
            in_data[sel]   = $urandom;
            if (out_valid[sel]) begin
                if (rdy) begin
                    e = exp_q.pop_front();
                    check34("out_data", out_data[sel], e);
                    check1("out_last", out_last[sel], beat == n - 1);
                    if (beat == n - 1) in_valid[sel] = 1'b0;
                    beat++;
                end else begin
                    held    = out_data[sel];
                    holding = 1'b1;
                end
            end
            @(negedge clk);
        end
        out_ready[sel] = 1'b0;
        in_valid[sel]  = 1'b0;
        check_int("unload_beats", beat, n);
        exp_q.delete();
        check1("done_pulse", done[sel], 1'b1);
        check1("out_valid_after", out_valid[sel], 1'b0);
        @(negedge clk);
        check1("done_low", done[sel], 1'b0);
        check1("in_ready_after", in_ready[sel], 1'b1);
        check_int("done_count", done_cnt[sel] - d0, 1);
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; in_data[s] = '0; out_ready[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check1("rst_in_ready", in_ready[s], 1'b1);
            check1("rst_out_valid", out_valid[s], 1'b0);
            check1("rst_busy", busy[s], 1'b0);
            check1("rst_done", done[s], 1'b0);
        end

        // 8-point ramp x[n] = n
        for (int i = 0; i < 32; i++) stim[i] = {16'(i), 16'd0};
        load(0, 8, 1'b0);
        push_ramp8();
        unload(0, 8, 1'b0);

        // 8-point constant 0+1j
        for (int i = 0; i < 32; i++) stim[i] = {16'd0, 16'd1};
        load(0, 8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pk(0, 2));
            exp_q.push_back(pk(0, 0));
        end
        unload(0, 8, 1'b0);

        // 32-point full-scale pair: growth bit must hold 65534
        for (int i = 0; i < 32; i++) stim[i] = '0;
        stim[0]  = {16'd32767, 16'd0};
        stim[16] = {16'd32767, 16'd0};
        load(1, 32, 1'b0);
        exp_q.push_back(pk(65534, 0));
        for (int i = 1; i < 32; i++) exp_q.push_back(pk(0, 0));
        unload(1, 32, 1'b0);

        // random data with input gaps and output backpressure
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) stim[i] = $urandom;
            load(s, s ? 32 : 8, 1'b1);
            push_model(s ? 32 : 8);
            unload(s, s ? 32 : 8, 1'b1);
        end

        // reset mid-load, then a clean ramp frame
        for (int i = 0; i < 32; i++) stim[i] = {16'(i), 16'd0};
        load(0, 5, 1'b0);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check1("midrst_in_ready", in_ready[0], 1'b1);
        check1("midrst_busy", busy[0], 1'b0);
        load(0, 8, 1'b0);
        push_ramp8();
        unload(0, 8, 1'b0);

        // back-to-back 32-point frames
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 32; i++) stim[i] = $urandom;
            load(1, 32, 1'b0);
            push_model(32);
            unload(1, 32, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
